// File: rtl/decim_avg_fifo_if.sv
// Stream bundle between the FIR/sink side and the decimating FIFO.
// The master drives samples and ready. The slave (the decimator) returns the FIFO head and status.
interface decim_avg_fifo_if;
    logic        valid_i;
    logic [15:0] data_i;
    logic [15:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic [6:0]  fill_o;
    logic        overflow_o;

    modport master (
        output valid_i, data_i, ready_i,
        input  data_o, valid_o, fill_o, overflow_o
    );

    modport slave (
        input  valid_i, data_i, ready_i,
        output data_o, valid_o, fill_o, overflow_o
    );
endinterface

// File: rtl/decim_avg_fifo.sv
// Integrate-and-dump decimator: averages DECIM samples with a floor shift.
// Each average is queued in a DEPTH-word FIFO behind a valid/ready handshake.
module decim_avg_fifo #(
    parameter int unsigned DECIM = 4,
    parameter int unsigned DEPTH = 8
) (
    input logic            clk,
    input logic            rst,
    decim_avg_fifo_if.slave bus
);
    localparam int unsigned S      = $clog2(DECIM);
    localparam int unsigned ACC_W  = 16 + S;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned FILL_W = 7;

    logic [S-1:0]      ph_q, ph_d;
    logic [ACC_W-1:0]  acc_q, acc_d, ext, sum;
    logic [15:0]       dump;
    logic              blk_done;

    logic [15:0]       mem [DEPTH];
    logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [15:0]       data_q, data_d;
    logic              valid_q, ovf_q, ovf_d;
    logic              pop, push, full;

    // Integrator: the first sample of a block reloads the accumulator instead of adding to it.
    always_comb begin
        ext      = {{S{bus.data_i[15]}}, bus.data_i};
        sum      = (ph_q == '0) ? ext : acc_q + ext;
        dump     = sum[S +: 16];
        blk_done = bus.valid_i && (ph_q == S'(DECIM - 1));
        ph_d     = ph_q;
        acc_d    = acc_q;
        if (bus.valid_i) begin
            acc_d = sum;
            ph_d  = blk_done ? '0 : ph_q + S'(1);
        end
    end

    // FIFO control. The next head word is registered so data_o is a plain flop.
    always_comb begin
        pop    = valid_q && bus.ready_i;
        full   = (fill_q == FILL_W'(DEPTH));
        push   = blk_done && (!full || pop);
        ovf_d  = ovf_q || (blk_done && full && !pop);
        rd_d   = rd_q + AW'(pop);
        wr_d   = wr_q + AW'(push);
        fill_d = fill_q + FILL_W'(push) - FILL_W'(pop);
        if (fill_d == '0)
            data_d = '0;
        else if (push && ((fill_q - FILL_W'(pop)) == '0))
            data_d = dump;
        else
            data_d = mem[rd_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q    <= '0;
            acc_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ph_q    <= ph_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            valid_q <= (fill_d != '0);
            ovf_q   <= ovf_d;
        end
    end

    // Storage array is not reset; data_o is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_q] <= dump;
    end

    assign bus.data_o     = data_q;
    assign bus.valid_o    = valid_q;
    assign bus.fill_o     = fill_q;
    assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_decim_avg_fifo.sv
// Randomized and directed bench for decim_avg_fifo.
// A queue-based reference model is compared against the DUT on every cycle.
module tb_decim_avg_fifo;
    localparam int unsigned DECIM = 4;
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    decim_avg_fifo_if bus();

    decim_avg_fifo #(.DECIM(DECIM), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int n_out = 0;

    // Reference model: a list of block samples and a queue of averaged words.
    int blk[$];
    int mq[$];
    bit m_ovf = 1'b0;
    bit started = 1'b0;

    function automatic int avg_floor(input int s);
        int q;
        q = s / int'(DECIM);
        if ((s % int'(DECIM)) != 0 && s < 0) q -= 1;
        return q;
    endfunction

    always @(posedge clk) begin
        bit m_pop, have_push;
        int w, s;
        started = 1'b1;
        if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1 && !rst) n_out++;
        if (rst) begin
            blk.delete();
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            m_pop = (mq.size() > 0) && bus.ready_i;
            have_push = 1'b0;
            w = 0;
            if (bus.valid_i) begin
                blk.push_back(int'($signed(bus.data_i)));
                if (blk.size() == DECIM) begin
                    s = 0;
                    foreach (blk[k]) s += blk[k];
                    w = avg_floor(s);
                    have_push = 1'b1;
                    blk.delete();
                end
            end
            if (m_pop) void'(mq.pop_front());
            if (have_push) begin
                if (mq.size() < DEPTH) mq.push_back(w);
                else m_ovf = 1'b1;
            end
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        logic [15:0] e_data;
        logic        e_valid;
        logic [6:0]  e_fill;
        if (started) begin
            e_valid = (mq.size() != 0);
            e_data  = e_valid ? 16'(mq[0]) : 16'd0;
            e_fill  = 7'(mq.size());
            vectors++;
            if (bus.valid_o !== e_valid || bus.data_o !== e_data ||
                bus.fill_o !== e_fill || bus.overflow_o !== m_ovf) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t got valid=%0b data=%0d fill=%0d ovf=%0b want valid=%0b data=%0d fill=%0d ovf=%0b",
                         $time, bus.valid_o, $signed(bus.data_o), bus.fill_o, bus.overflow_o,
                         e_valid, $signed(e_data), e_fill, m_ovf);
            end
        end
    end

    task automatic drive(input bit v, input int d, input bit r);
        bus.valid_i = v;
        bus.data_i  = 16'(d);
        bus.ready_i = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string name, input int exp_data, input int exp_fill, input bit exp_ovf);
        logic [15:0] ed;
        ed = 16'(exp_data);
        vectors++;
        if (bus.data_o !== ed || bus.fill_o !== 7'(exp_fill) ||
            bus.valid_o !== (exp_fill != 0) || bus.overflow_o !== exp_ovf) begin
            miscompares++;
            $display("FAIL %s got data=%0d fill=%0d valid=%0b ovf=%0b want data=%0d fill=%0d ovf=%0b",
                     name, $signed(bus.data_o), bus.fill_o, bus.valid_o, bus.overflow_o,
                     exp_data, exp_fill, exp_ovf);
        end
    endtask

    task automatic feed4(input int a, input int b, input int c, input int d, input bit r);
        drive(1'b1, a, r);
        drive(1'b1, b, r);
        drive(1'b1, c, r);
        drive(1'b1, d, r);
    endtask

    initial begin
        int n0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.ready_i = 1'b0;

        // Reset held with input activity
        rst = 1'b1;
        drive(1'b1, 123, 1'b1);
        check_lit("reset_c1", 0, 0, 1'b0);
        drive(1'b0, 0, 1'b1);
        check_lit("reset_c2", 0, 0, 1'b0);
        rst = 1'b0;

        // Plain average, one-cycle visibility
        feed4(100, 200, 300, 400, 1'b1);
        check_lit("avg_250", 250, 1, 1'b0);
        drive(1'b0, 0, 1'b1);
        check_lit("avg_popped", 0, 0, 1'b0);

        // Floor toward -inf and extremes
        feed4(-1, -1, -1, 0, 1'b1);
        check_lit("neg_floor", -1, 1, 1'b0);
        feed4(32767, 32767, 32767, 32767, 1'b1);
        check_lit("max_pos", 32767, 1, 1'b0);
        feed4(-32768, -32768, -32768, -32768, 1'b1);
        check_lit("max_neg", -32768, 1, 1'b0);
        drive(1'b0, 0, 1'b1);

        // Gapped input
        n0 = n_out;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i, 1'b1);
            if (i == 4) check_lit("gap_first", 2, 1, 1'b0);
            if (i == 8) check_lit("gap_second", 6, 1, 1'b0);
            drive(1'b0, 0, 1'b1);
            drive(1'b0, 0, 1'b1);
        end
        vectors++;
        if (n_out - n0 != 2) begin
            miscompares++;
            $display("FAIL gap_count got %0d outputs want 2", n_out - n0);
        end

        // Overflow: nine blocks into an eight-deep FIFO
        for (int k = 1; k <= 9; k++) feed4(k * 10, k * 10, k * 10, k * 10, 1'b0);
        check_lit("ovf_full", 10, 8, 1'b1);
        drive(1'b1, 100, 1'b0);
        drive(1'b1, 100, 1'b0);
        drive(1'b1, 100, 1'b0);
        drive(1'b1, 100, 1'b1);
        check_lit("ovf_push_pop", 20, 8, 1'b1);
        for (int k = 0; k < 8; k++) drive(1'b0, 0, 1'b1);
        check_lit("ovf_drained", 0, 0, 1'b1);

        // Reset mid-block discards the partial sum
        drive(1'b1, 1000, 1'b1);
        drive(1'b1, 1000, 1'b1);
        rst = 1'b1;
        drive(1'b0, 0, 1'b1);
        rst = 1'b0;
        feed4(4, 4, 4, 4, 1'b1);
        check_lit("rst_midblk", 4, 1, 1'b0);
        drive(1'b0, 0, 1'b1);

        // Random traffic with long ready-low stretches and rare resets
        for (int c = 0; c < 3000; c++) begin
            bit r;
            r = ((c / 64) % 3 == 1) ? 1'b0 : ($urandom_range(0, 9) < 6);
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 65535)), r);
        end
        rst = 1'b0;
        for (int c = 0; c < 12; c++) drive(1'b0, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
